imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 12 +
 rtl/imem_loader.sv | 94 +++++++++
 tb/tb_imem_loader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: state encoding and stream framing constants shared by the loader and its bench.
package imem_loader_pkg;
  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_e;
  localparam int HDR_LEN = 2;
endpackage

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed, XOR-checksummed image into instruction memory and
// holds the CPU in reset until a load completes with a good checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);
  localparam logic [16:0] MAX_N = 17'(MEM_BYTES);
  state_e            state_q, state_d;
  logic [7:0]        lo_q, lo_d, csum_q, csum_d, wdata_q, wdata_d;
  logic [ADDR_W:0]   len_q, len_d, cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d, acc;
  logic [15:0]       n;
  assign in_ready  = (state_q != S_DONE) && (state_q != S_ERR);
  assign acc       = in_valid && in_ready;
  assign n         = {in_data, lo_q};
  assign cnt_inc   = cnt_q + 1'b1;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rst   = state_q != S_DONE;
  assign done      = state_q == S_DONE;
  assign err       = state_q == S_ERR;
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_LEN_LO: if (acc) begin
        lo_d    = in_data;
        state_d = S_LEN_HI;
      end
      S_LEN_HI: if (acc) begin
        len_d   = n[ADDR_W:0];
        state_d = (n == 16'd0) ? S_CSUM : ({1'b0, n} > MAX_N) ? S_ERR : S_DATA;
      end
      S_DATA: if (acc) begin
        we_d    = 1'b1;
        addr_d  = cnt_q[ADDR_W-1:0];
        wdata_d = in_data;
        csum_d  = csum_q ^ in_data;
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == len_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: if (acc) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
      default: if (reload) begin
        state_d = S_LEN_LO;
        cnt_d   = '0;
        csum_d  = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_LEN_LO;
      lo_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table vectors, random streams against a stream-level model, and reset/reload corners.
module tb_imem_loader;
  import imem_loader_pkg::*;
  localparam int MB = 1024;
  localparam int AW = 10;
  logic          clk = 0, rst = 0, in_valid = 0, reload = 0;
  logic [7:0]    in_data = 0;
  logic          in_ready, mem_we, cpu_rst, done, err;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  int passed = 0, total = 0;
  logic [AW-1:0] wa_q[$];
  logic [7:0]    wd_q[$];
  typedef struct {
    logic [7:0] b[8];
    int         n;
    bit         exp_done;
    int         exp_w;
  } vec_t;
  vec_t vt[5];

  imem_loader #(.MEM_BYTES(MB), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we) begin
    wa_q.push_back(mem_addr);
    wd_q.push_back(mem_wdata);
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    in_valid = 1;
    in_data  = b;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
      end
    end
    in_valid = 0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model: the header says N; an oversize N rejects after the header, otherwise the
  // payload lands at 0..N-1 and the outcome is the XOR of the payload against the trailer.
  task automatic run_stream(input logic [7:0] s[$], input int max_gap, input string tag);
    int n, used, nw;
    logic [7:0] x = 0;
    bit good;
    wa_q.delete();
    wd_q.delete();
    n = int'({s[1], s[0]});
    used = (n > MB) ? HDR_LEN : n + HDR_LEN + 1;
    for (int i = 0; i < used; i++) begin
      idle($urandom_range(max_gap, 0));
      send_byte(s[i]);
    end
    idle(2);
    if (n > MB) begin
      good = 0;
      nw = 0;
    end else begin
      for (int k = 0; k < n; k++) x ^= s[HDR_LEN + k];
      good = (s[HDR_LEN + n] == x);
      nw = n;
    end
    check({tag, "_nwrites"}, wa_q.size(), nw);
    for (int k = 0; k < nw && k < wa_q.size(); k++) begin
      check($sformatf("%s_addr%0d", tag, k), int'(wa_q[k]), k);
      check($sformatf("%s_data%0d", tag, k), int'(wd_q[k]), int'(s[HDR_LEN + k]));
    end
    check({tag, "_done"}, int'(done), int'(good));
    check({tag, "_err"}, int'(err), int'(!good));
    check({tag, "_cpu_rst"}, int'(cpu_rst), int'(!good));
  endtask

  task automatic do_reload(input string tag);
    reload = 1;
    idle(1);
    reload = 0;
    check({tag, "_rl_cpu_rst"}, int'(cpu_rst), 1);
    check({tag, "_rl_ready"}, int'(in_ready), 1);
    check({tag, "_rl_done"}, int'(done), 0);
    check({tag, "_rl_err"}, int'(err), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"}, int'(mem_we), 0);
    check({tag, "_addr"}, int'(mem_addr), 0);
    check({tag, "_wdata"}, int'(mem_wdata), 0);
    check({tag, "_cpu_rst"}, int'(cpu_rst), 1);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    logic [7:0] s[$];
    int n;
    logic [7:0] x;
    vt[0].b = '{8'h04, 8'h00, 8'h8C, 8'h01, 8'h00, 8'h00, 8'h8D, 8'h00}; vt[0].n = 7; vt[0].exp_done = 1; vt[0].exp_w = 4;
    vt[1].b = '{8'h04, 8'h00, 8'h8C, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00}; vt[1].n = 7; vt[1].exp_done = 0; vt[1].exp_w = 4;
    vt[2].b = '{8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; vt[2].n = 2; vt[2].exp_done = 0; vt[2].exp_w = 0;
    vt[3].b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; vt[3].n = 3; vt[3].exp_done = 1; vt[3].exp_w = 0;
    vt[4].b = '{8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; vt[4].n = 3; vt[4].exp_done = 0; vt[4].exp_w = 0;

    idle(3);
    check_reset_vals("reset");
    rst = 1;
    idle(1);

    for (int v = 0; v < 5; v++) begin
      s.delete();
      for (int i = 0; i < vt[v].n; i++) s.push_back(vt[v].b[i]);
      run_stream(s, 2, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_tbl_done", v), int'(done), int'(vt[v].exp_done));
      check($sformatf("vec%0d_tbl_nw", v), wa_q.size(), vt[v].exp_w);
      for (int k = 0; k < vt[v].exp_w && k < wd_q.size(); k++)
        check($sformatf("vec%0d_tbl_data%0d", v, k), int'(wd_q[k]), int'(vt[v].b[HDR_LEN + k]));
      if (v == 2) begin
        in_valid = 1;
        in_data = 8'h77;
        idle(3);
        in_valid = 0;
        check("stall_err_held", int'(err), 1);
        check("stall_no_write", wa_q.size(), 0);
        check("stall_not_ready", int'(in_ready), 0);
      end
      do_reload($sformatf("vec%0d", v));
    end

    wa_q.delete();
    wd_q.delete();
    send_byte(8'h03); send_byte(8'h00); send_byte(8'hAA);
    reload = 1;
    idle(1);
    reload = 0;
    check("rl_data_ready", int'(in_ready), 1);
    check("rl_data_err", int'(err), 0);
    send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    idle(2);
    check("rl_data_nw", wa_q.size(), 3);
    if (wd_q.size() == 3) check("rl_data_last", int'(wd_q[2]), 8'hCC);
    check("rl_data_done", int'(done), 1);
    do_reload("rl_data");

    for (int r = 0; r < 14; r++) begin
      s.delete();
      n = (r == 13) ? MB + 1 + $urandom_range(3000, 0) : $urandom_range(40, 0);
      s.push_back(n[7:0]);
      s.push_back(n[15:8]);
      x = 0;
      for (int k = 0; k < n && k < MB; k++) begin
        s.push_back(8'($urandom_range(255, 0)));
        x ^= s[s.size() - 1];
      end
      s.push_back($urandom_range(1, 0) ? x : x ^ 8'($urandom_range(255, 1)));
      run_stream(s, 3, $sformatf("rnd%0d", r));
      do_reload($sformatf("rnd%0d", r));
    end

    s.delete();
    s.push_back(8'h00);
    s.push_back(8'h04);
    x = 0;
    for (int k = 0; k < MB; k++) begin
      s.push_back(8'($urandom_range(255, 0)));
      x ^= s[s.size() - 1];
    end
    s.push_back(x);
    run_stream(s, 2, "full");
    if (wa_q.size() > 0) check("full_last_addr", int'(wa_q[wa_q.size() - 1]), 'h3FF);
    do_reload("full");

    wa_q.delete();
    wd_q.delete();
    send_byte(8'h14); send_byte(8'h00);
    for (int k = 0; k < 5; k++) send_byte(8'(8'h30 + k));
    @(negedge clk);
    in_valid = 1;
    in_data = 8'h55;
    #2 rst = 0;
    #1 check_reset_vals("midrst");
    idle(3);
    check("midrst_nw", wa_q.size(), 5);
    if (wd_q.size() == 5) check("midrst_kept", int'(wd_q[4]), 8'h34);
    in_valid = 0;
    rst = 1;
    idle(1);
    s.delete();
    for (int i = 0; i < vt[0].n; i++) s.push_back(vt[0].b[i]);
    run_stream(s, 1, "post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
